kernel_gather: RTL

- Stage 1 of the Gaussian pyramid builder. Walks every center pixel of one pyramid-level image in raster order.
- For each center, reads the 3x3 neighbourhood one pixel per cycle from a pyramid/frame BRAM read port, saturating coordinates at the image edges.
- Presents the three packed kernel rows to the gaussian blur stage through a valid/ready handshake, along with the center coordinates for the downstream write-back.

---
 rtl/kernel_gather.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/kernel_gather.sv
// rtl/kernel_gather.sv - 3x3 neighbourhood gather for the Gaussian pyramid builder
//
// Walks every center pixel of one image in raster order. For each center it reads
// the edge-clamped 3x3 neighbourhood from a BRAM port, one pixel per cycle, and
// presents it as three packed rows through a valid/ready handshake.
//
// Ports:
//   clk_in, rst_in              clock, synchronous active-high reset
//   start_in, width_in,         start a pass; dimensions latched when accepted
//   height_in
//   read_addr_out, read_en_out  BRAM read request
//   read_data_in                BRAM data, BRAM_LATENCY cycles after the request
//   r0/r1/r2_data_out           kernel rows above / at / below the center, left pixel in LSBs
//   center_x_out, center_y_out  center coordinates of the presented kernel
//   data_valid_out, ready_in    kernel handshake
//   busy_out, done_out          pass in progress / one-cycle end-of-pass pulse
module kernel_gather #(
    parameter int BIT_DEPTH    = 8,
    parameter int MAX_WIDTH    = 128,
    parameter int MAX_HEIGHT   = 128,
    parameter int BRAM_LATENCY = 2,
    parameter int DIM_W        = $clog2(MAX_WIDTH) + 1,
    parameter int ADDR_W       = $clog2(MAX_WIDTH * MAX_HEIGHT)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [DIM_W-1:0]       width_in,
    input  logic [DIM_W-1:0]       height_in,
    output logic [ADDR_W-1:0]      read_addr_out,
    output logic                   read_en_out,
    input  logic [BIT_DEPTH-1:0]   read_data_in,
    output logic [3*BIT_DEPTH-1:0] r0_data_out,
    output logic [3*BIT_DEPTH-1:0] r1_data_out,
    output logic [3*BIT_DEPTH-1:0] r2_data_out,
    output logic [DIM_W-2:0]       center_x_out,
    output logic [DIM_W-2:0]       center_y_out,
    output logic                   data_valid_out,
    input  logic                   ready_in,
    output logic                   busy_out,
    output logic                   done_out
);

    localparam int PW = ADDR_W + DIM_W;
    localparam logic signed [DIM_W:0] S_ONE  = 1;
    localparam logic signed [DIM_W:0] S_ZERO = 0;
    localparam logic [DIM_W-1:0]      D_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0]      w_q, h_q;
    logic [DIM_W-2:0]      cx, cy;
    logic [1:0]            kx, ky;
    logic [3:0]            k_issue;
    logic [BRAM_LATENCY-1:0] pv;
    logic [3:0]            pk [BRAM_LATENCY];
    logic [BIT_DEPTH-1:0]  slot [9];

    logic dims_ok, last_issue, capture_last, last_x, last_y;
    logic signed [DIM_W:0] tx, ty, wm1, hm1, sx, sy;

    assign dims_ok = (width_in != '0) && (width_in <= DIM_W'(MAX_WIDTH)) &&
                     (height_in != '0) && (height_in <= DIM_W'(MAX_HEIGHT));
    assign k_issue      = {1'b0, ky, 1'b0} + {2'b00, ky} + {2'b00, kx};
    assign last_issue   = (kx == 2'd2) && (ky == 2'd2);
    // Slot 8 is the last read of a kernel; its arrival closes the WAIT phase.
    assign capture_last = pv[BRAM_LATENCY-1] && (pk[BRAM_LATENCY-1] == 4'd8);
    assign last_x       = ({1'b0, cx} == w_q - D_ONE);
    assign last_y       = ({1'b0, cy} == h_q - D_ONE);

    // Edge clamp in signed arithmetic one bit wider than the dimensions, so the
    // neighbour left of / above coordinate 0 is -1 rather than a wrapped value.
    always_comb begin
        tx  = $signed({2'b00, cx}) + $signed({{(DIM_W-1){1'b0}}, kx}) - S_ONE;
        ty  = $signed({2'b00, cy}) + $signed({{(DIM_W-1){1'b0}}, ky}) - S_ONE;
        wm1 = $signed({1'b0, w_q}) - S_ONE;
        hm1 = $signed({1'b0, h_q}) - S_ONE;
        sx  = tx;
        if (tx < S_ZERO)   sx = S_ZERO;
        else if (tx > wm1) sx = wm1;
        sy  = ty;
        if (ty < S_ZERO)   sy = S_ZERO;
        else if (ty > hm1) sy = hm1;
    end

    assign read_en_out    = (state == S_FETCH);
    assign read_addr_out  = (state == S_FETCH) ?
                            ADDR_W'(PW'(sy) * PW'(w_q) + PW'(sx)) : '0;
    assign data_valid_out = (state == S_PRESENT);
    assign busy_out       = (state != S_IDLE);
    assign done_out       = (state == S_DONE);
    assign center_x_out   = cx;
    assign center_y_out   = cy;
    assign r0_data_out    = {slot[2], slot[1], slot[0]};
    assign r1_data_out    = {slot[5], slot[4], slot[3]};
    assign r2_data_out    = {slot[8], slot[7], slot[6]};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_in && dims_ok) state_nxt = S_FETCH;
            S_FETCH:   if (last_issue) state_nxt = S_WAIT;
            S_WAIT:    if (capture_last) state_nxt = S_PRESENT;
            S_PRESENT: if (ready_in) state_nxt = (last_x && last_y) ? S_DONE : S_FETCH;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
            w_q   <= '0;
            h_q   <= '0;
            cx    <= '0;
            cy    <= '0;
            kx    <= '0;
            ky    <= '0;
            pv    <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) pk[i] <= '0;
            for (int i = 0; i < 9; i++) slot[i] <= '0;
        end else begin
            state <= state_nxt;

            // Read tag pipeline: each issued k travels alongside its BRAM read.
            pv[0] <= read_en_out;
            pk[0] <= k_issue;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pk[i] <= pk[i-1];
            end
            if (pv[BRAM_LATENCY-1]) slot[pk[BRAM_LATENCY-1]] <= read_data_in;

            case (state)
                S_IDLE: begin
                    if (start_in && dims_ok) begin
                        w_q <= width_in;
                        h_q <= height_in;
                        cx  <= '0;
                        cy  <= '0;
                        kx  <= '0;
                        ky  <= '0;
                    end
                end
                S_FETCH: begin
                    if (kx == 2'd2) begin
                        kx <= '0;
                        ky <= (ky == 2'd2) ? 2'd0 : ky + 2'd1;
                    end else begin
                        kx <= kx + 2'd1;
                    end
                end
                S_PRESENT: begin
                    if (ready_in) begin
                        if (!last_x) begin
                            cx <= cx + 1'b1;
                        end else if (!last_y) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
